// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM states, frame
// layout and default filter/timeout settings.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int FRAME_BITS = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;

  localparam logic [3:0] PARITY_IDX = 4'd9;
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

  localparam int DEFAULT_FILTER_LEN = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 20000;

  // Odd parity over data+parity, plus a correct stop bit.
  function automatic logic frame_good(input logic [7:0] data, input logic parity,
                                      input logic stop);
    return (((^data) ^ parity) == 1'b1) && (stop == STOP_BIT);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the filtered level only
// follows the line after FILTER_LEN consecutive samples at the new level.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// Receive-only PS/2 device-to-host deframer. Filters both lines, detects
// falling clock edges and assembles 11-bit frames into a byte plus error flag.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic [7:0] rx_data,
  output logic       read_data,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic filt_clk, filt_data;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_clk),
    .filt_o (filt_clk)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_data),
    .filt_o (filt_data)
  );

  // Edge detect is registered; data is registered alongside so the sampled
  // bit stays aligned with its event.
  logic clk_prev_q, event_q, event_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_q   <= 1'b1;
      event_q      <= 1'b0;
      event_data_q <= 1'b1;
    end else begin
      clk_prev_q   <= filt_clk;
      event_q      <= clk_prev_q & ~filt_clk;
      event_data_q <= filt_data;
    end
  end

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [7:0]    rx_q, rx_d;
  logic          err_q, err_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          good;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    rx_d      = rx_q;
    err_d     = err_q;
    timeout_d = '0;
    good      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (event_q && (event_data_q == START_BIT)) begin
          state_d   = RECEIVE;
          bit_cnt_d = 4'd1;
          shift_d   = '0;
        end
      end

      RECEIVE: begin
        if (event_q) begin
          if (bit_cnt_q == STOP_IDX) begin
            good      = frame_good(shift_q, parity_q, event_data_q);
            err_d     = ~good;
            if (good) rx_d = shift_q;
            state_d   = DONE;
            bit_cnt_d = '0;
          end else if (bit_cnt_q == PARITY_IDX) begin
            parity_d  = event_data_q;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            shift_d   = {event_data_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Line went quiet mid-frame: abort with the byte left untouched.
          err_d     = 1'b1;
          state_d   = DONE;
          bit_cnt_d = '0;
        end else begin
          timeout_d = timeout_q + TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign rx_data   = rx_q;
  assign err       = err_q;
  assign read_data = (state_q == DONE);
  assign busy      = (state_q == RECEIVE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed framing/timeout/glitch/reset
// cases followed by random frames scored against a byte-level model.
`timescale 1ns/1ps
module tb_ps2_receiver;

  localparam int FLT  = 8;
  localparam int TMO  = 400;
  localparam int HALF = 40;
  localparam int LAT  = 2 + FLT + 1 + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_drv = 1'b1;
  logic dat_drv = 1'b1;
  wire  ps2_clk;
  wire  ps2_data;
  assign ps2_clk  = clk_drv;
  assign ps2_data = dat_drv;

  logic [7:0] rx_data;
  logic       read_data, busy, err;

  ps2_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_data   (rx_data),
    .read_data (read_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fall = 0;
  int strobes = 0;
  int last_lat = 0;
  logic [7:0] strobe_rx = '0;
  logic       strobe_err = 1'b0;
  logic       busy_mid = 1'b0;
  logic [7:0] exp_rx = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (read_data === 1'b1) begin
      strobes++;
      strobe_rx  = rx_data;
      strobe_err = err;
      last_lat   = cyc - last_fall;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then clock low for half a period.
  // With glitch set, data is inverted for 3 cycles straddling the falling edge.
  task automatic ps2_bit(input logic b, input logic glitch);
    dat_drv = b;
    if (glitch) begin
      repeat (HALF - 1) @(negedge clk);
      dat_drv = ~b;
      @(negedge clk);
      clk_drv = 1'b0;
      last_fall = cyc;
      repeat (2) @(negedge clk);
      dat_drv = b;
      repeat (HALF - 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
      clk_drv = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
    end
    clk_drv = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input logic glitch);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == 10) busy_mid = busy;
      ps2_bit(bits[i], glitch);
    end
    dat_drv = 1'b1;
    clk_drv = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_strobe(input int pre, input int budget);
    for (int i = 0; i < budget && strobes == pre; i++) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                           input logic stop, input logic glitch);
    int  pre;
    int  ones;
    logic exp_err;
    pre = strobes;
    send_frame(b, par, stop, 11, glitch);
    wait_strobe(pre, 200);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    ones += int'(par);
    exp_err = !((ones % 2 == 1) && stop);
    if (!exp_err) exp_rx = b;
    check({tag, "_strobes"}, strobes - pre, 1);
    check({tag, "_rx"}, strobe_rx, exp_rx);
    check({tag, "_err"}, strobe_err, exp_err);
    check({tag, "_latency"}, last_lat, LAT);
    check({tag, "_busy_mid"}, busy_mid, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_rx_held"}, rx_data, exp_rx);
  endtask

  initial begin
    int pre;
    logic [7:0] rb;
    logic rp, rs;

    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx", rx_data, 8'h00);
    check("reset_read", read_data, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    run_frame("f1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    run_frame("ff0", 8'hF0, 1'b1, 1'b1, 1'b0);
    run_frame("f1c_b", 8'h1C, 1'b0, 1'b1, 1'b0);
    run_frame("bad_par", 8'h1C, 1'b1, 1'b1, 1'b0);

    // Clock stops after 5 bits: expect an aborted frame after the timeout.
    pre = strobes;
    send_frame(8'hAA, 1'b1, 1'b1, 5, 1'b0);
    wait_strobe(pre, TMO + 200);
    check("tmo_strobes", strobes - pre, 1);
    check("tmo_err", strobe_err, 1'b1);
    check("tmo_rx", strobe_rx, exp_rx);
    check("tmo_latency", last_lat, TMO + LAT);
    check("tmo_busy_after", busy, 1'b0);
    run_frame("f29", 8'h29, 1'b0, 1'b1, 1'b0);

    // Short clock glitch while idle, then a frame with data glitches.
    pre = strobes;
    clk_drv = 1'b0;
    repeat (3) @(negedge clk);
    clk_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_idle_strobes", strobes - pre, 0);
    check("glitch_idle_busy", busy, 1'b0);
    run_frame("glitch_data", 8'h5A, 1'b1, 1'b1, 1'b1);
    run_frame("after_glitch", 8'h3B, 1'b0, 1'b1, 1'b0);

    // Reset pulse mid-frame: drop partial frame, no strobe.
    pre = strobes;
    send_frame(8'h77, 1'b0, 1'b1, 7, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    exp_rx = 8'h00;
    check("midrst_rx", rx_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_read", read_data, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_strobes", strobes - pre, 0);
    run_frame("after_rst", 8'h1C, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      rp = ~(^rb);
      if ($urandom_range(0, 3) == 0) rp = ~rp;
      rs = ($urandom_range(0, 7) != 0);
      run_frame("rand", rb, rp, rs, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
